// File: rtl/sdram_device_model.sv
// sdram_device_model: responder end of an SDR SDRAM pin interface.
// Decodes CS/RAS/CAS/WE commands and tracks the init sequence, per-bank
// open row and tRCD, the mode register, write bursts with DQM byte masking
// and CAS-latency read pipelining. Protocol violations pulse err and
// latch a cause in err_code.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cke                          clock enable; 0 freezes every register
//   cs_n, ras_n, cas_n, we_n     command pins
//   ba[1:0], addr[11:0]          bank / row / column / mode address
//   dqm[1:0]                     byte mask (write: same cycle, read: 2-cycle latency)
//   dq_i[15:0]                   write data
//   dq_o[15:0], dq_oe            registered read data and drive enable
//   init_done                    init sequence complete
//   err, err_code[2:0]           violation pulse and its latched cause
//   refresh_cnt[15:0]            saturating AUTO REFRESH count
module sdram_device_model #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 8,
    parameter int unsigned TRCD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  ba,
    input  logic [11:0] addr,
    input  logic [1:0]  dqm,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        init_done,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);
    localparam int unsigned AW = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned TW = (TRCD < 2) ? 1 : $clog2(TRCD);
    localparam logic [TW-1:0] TrcdLoad = TW'(TRCD - 1);

    typedef enum logic [1:0] {StWaitPall, StWaitRef, StWaitLmr, StDone} init_e;

    init_e state_q, state_d;
    logic ref_seen_q, ref_seen_d;
    logic [3:0] open_q, open_d;
    logic [3:0][ROW_BITS-1:0] row_q, row_d;
    logic [3:0][TW-1:0] trcd_q, trcd_d;
    logic [2:0] bl_q, bl_d;
    logic cl3_q, cl3_d, wb_q, wb_d;
    logic bst_act_q, bst_act_d, bst_wr_q, bst_wr_d, bst_full_q, bst_full_d, bst_ap_q, bst_ap_d;
    logic [1:0] bst_bank_q, bst_bank_d;
    logic [COL_BITS-1:0] bst_col_q, bst_col_d, bst_left_q, bst_left_d, bst_mask_q, bst_mask_d;
    logic p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
    logic [15:0] p1_dat_q, p1_dat_d, p2_dat_q, p2_dat_d;
    logic [1:0] dqm_q;
    logic [15:0] dq_o_q, dq_o_d;
    logic dq_oe_q, dq_oe_d, err_q, err_d;
    logic [2:0] err_code_q, err_code_d;
    logic [15:0] ref_cnt_q, ref_cnt_d;

    logic [15:0] mem [2**AW];

    logic cmd_vld, exec_act, exec_rd, exec_wr, exec_pre, exec_ref, exec_lmr, is_bst;
    logic [2:0] viol;
    logic beat, beat_wr, beat_full, beat_ap, beat_last, bst_stop, mem_we;
    logic [1:0] beat_bank;
    logic [COL_BITS-1:0] beat_col, beat_left, beat_mask, bl_mask;
    logic [AW-1:0] beat_addr;
    logic [15:0] rd_word;
    logic src_vld;
    logic [15:0] src_dat;
    logic unused_addr;

    assign unused_addr = ^{addr[11], addr[8:7]};
    assign init_done   = (state_q == StDone);
    assign cmd_vld     = cke & ~cs_n;

    // Command decode and violation check; erroneous commands do not execute.
    always_comb begin
        viol = 3'd0;
        exec_act = 1'b0; exec_rd = 1'b0; exec_wr = 1'b0;
        exec_pre = 1'b0; exec_ref = 1'b0; exec_lmr = 1'b0; is_bst = 1'b0;
        if (cmd_vld) begin
            case ({ras_n, cas_n, we_n})
                3'b011: begin
                    if (!init_done) viol = 3'd1;
                    else if (open_q[ba]) viol = 3'd2;
                    else exec_act = 1'b1;
                end
                3'b101, 3'b100: begin
                    if (!init_done) viol = 3'd1;
                    else if (!open_q[ba]) viol = 3'd3;
                    else if (trcd_q[ba] != '0) viol = 3'd4;
                    else if (we_n) exec_rd = 1'b1;
                    else exec_wr = 1'b1;
                end
                3'b010: exec_pre = 1'b1;
                3'b001, 3'b000: begin
                    if (|open_q) viol = 3'd5;
                    else if (we_n) exec_ref = 1'b1;
                    else exec_lmr = 1'b1;
                end
                3'b110: is_bst = 1'b1;
                default: ;
            endcase
        end
        // Interleaved or unsupported CL still loads (as sequential / CL2) but is flagged.
        if (exec_lmr && (addr[3] || (addr[6:4] != 3'd2 && addr[6:4] != 3'd3))) viol = 3'd6;
    end

    // Burst engine: one beat per enabled edge, beat 0 on the command edge itself.
    always_comb begin
        case (bl_q)
            3'b001:  bl_mask = COL_BITS'(1);
            3'b010:  bl_mask = COL_BITS'(3);
            3'b011:  bl_mask = COL_BITS'(7);
            3'b111:  bl_mask = '1;
            default: bl_mask = '0;
        endcase
        bst_stop  = is_bst | (exec_pre & (addr[10] | (ba == bst_bank_q)));
        beat      = 1'b0;
        beat_wr   = bst_wr_q;
        beat_bank = bst_bank_q;
        beat_col  = bst_col_q;
        beat_left = bst_left_q;
        beat_mask = bst_mask_q;
        beat_full = bst_full_q;
        beat_ap   = bst_ap_q;
        if (exec_rd || exec_wr) begin
            beat      = 1'b1;
            beat_wr   = exec_wr;
            beat_bank = ba;
            beat_col  = addr[COL_BITS-1:0];
            beat_mask = (exec_wr && wb_q) ? '0 : bl_mask;
            beat_full = !(exec_wr && wb_q) && (bl_q == 3'b111);
            beat_left = beat_mask;  // burst length minus one
            beat_ap   = addr[10];
        end else if (bst_act_q && !bst_stop) begin
            beat = 1'b1;
        end
        beat_last  = !beat_full && (beat_left == '0);
        bst_act_d  = bst_act_q & ~bst_stop;
        bst_wr_d   = bst_wr_q;
        bst_bank_d = bst_bank_q;
        bst_col_d  = bst_col_q;
        bst_left_d = bst_left_q;
        bst_mask_d = bst_mask_q;
        bst_full_d = bst_full_q;
        bst_ap_d   = bst_ap_q;
        if (beat) begin
            bst_act_d  = !beat_last;
            bst_wr_d   = beat_wr;
            bst_bank_d = beat_bank;
            bst_col_d  = (beat_col & ~beat_mask) | ((beat_col + COL_BITS'(1)) & beat_mask);
            bst_left_d = beat_left - COL_BITS'(1);
            bst_mask_d = beat_mask;
            bst_full_d = beat_full;
            bst_ap_d   = beat_ap;
        end
        beat_addr = {beat_bank, row_q[beat_bank], beat_col};
        mem_we    = cke & ~rst & beat & beat_wr;
    end

    assign rd_word = mem[beat_addr];

    // Bank, mode, init and error next state.
    always_comb begin
        state_d    = state_q;
        ref_seen_d = ref_seen_q;
        open_d     = open_q;
        row_d      = row_q;
        for (int i = 0; i < 4; i++) begin
            trcd_d[i] = (trcd_q[i] != '0) ? trcd_q[i] - TW'(1) : '0;
        end
        bl_d      = bl_q;
        cl3_d     = cl3_q;
        wb_d      = wb_q;
        ref_cnt_d = ref_cnt_q;
        if (exec_act) begin
            open_d[ba] = 1'b1;
            row_d[ba]  = addr[ROW_BITS-1:0];
            trcd_d[ba] = TrcdLoad;
        end
        if (exec_pre) begin
            if (addr[10]) open_d = '0;
            else open_d[ba] = 1'b0;
        end
        if (beat && beat_last && beat_ap) open_d[beat_bank] = 1'b0;
        if (exec_ref && ref_cnt_q != 16'hFFFF) ref_cnt_d = ref_cnt_q + 16'd1;
        if (exec_lmr) begin
            bl_d  = addr[2:0];
            cl3_d = (addr[6:4] == 3'd3);
            wb_d  = addr[9];
        end
        case (state_q)
            StWaitPall: if (exec_pre && addr[10]) begin
                state_d    = StWaitRef;
                ref_seen_d = 1'b0;
            end
            StWaitRef: if (exec_ref) begin
                if (ref_seen_q) state_d = StWaitLmr;
                ref_seen_d = 1'b1;
            end
            StWaitLmr: if (exec_lmr) state_d = StDone;
            default: ;
        endcase
        err_d      = (viol != 3'd0);
        err_code_d = err_d ? viol : err_code_q;
    end

    // Read pipeline: beat data enters p1; CL2 drives from p1, CL3 from p2.
    always_comb begin
        p1_vld_d = beat & ~beat_wr;
        p1_dat_d = rd_word;
        p2_vld_d = p1_vld_q;
        p2_dat_d = p1_dat_q;
        src_vld  = cl3_q ? p2_vld_q : p1_vld_q;
        src_dat  = cl3_q ? p2_dat_q : p1_dat_q;
        dq_oe_d  = src_vld & ~(&dqm_q);
        dq_o_d   = src_vld ? (src_dat & {{8{~dqm_q[1]}}, {8{~dqm_q[0]}}}) : dq_o_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitPall; ref_seen_q <= 1'b0;
            open_q <= '0; row_q <= '0; trcd_q <= '0;
            bl_q <= 3'd0; cl3_q <= 1'b0; wb_q <= 1'b0;
            bst_act_q <= 1'b0; bst_wr_q <= 1'b0; bst_full_q <= 1'b0; bst_ap_q <= 1'b0;
            bst_bank_q <= 2'd0; bst_col_q <= '0; bst_left_q <= '0; bst_mask_q <= '0;
            p1_vld_q <= 1'b0; p2_vld_q <= 1'b0; p1_dat_q <= '0; p2_dat_q <= '0;
            dqm_q <= 2'b00; dq_o_q <= '0; dq_oe_q <= 1'b0;
            err_q <= 1'b0; err_code_q <= 3'd0; ref_cnt_q <= '0;
        end else if (cke) begin
            state_q <= state_d; ref_seen_q <= ref_seen_d;
            open_q <= open_d; row_q <= row_d; trcd_q <= trcd_d;
            bl_q <= bl_d; cl3_q <= cl3_d; wb_q <= wb_d;
            bst_act_q <= bst_act_d; bst_wr_q <= bst_wr_d; bst_full_q <= bst_full_d;
            bst_ap_q <= bst_ap_d; bst_bank_q <= bst_bank_d; bst_col_q <= bst_col_d;
            bst_left_q <= bst_left_d; bst_mask_q <= bst_mask_d;
            p1_vld_q <= p1_vld_d; p2_vld_q <= p2_vld_d; p1_dat_q <= p1_dat_d; p2_dat_q <= p2_dat_d;
            dqm_q <= dqm; dq_o_q <= dq_o_d; dq_oe_q <= dq_oe_d;
            err_q <= err_d; err_code_q <= err_code_d; ref_cnt_q <= ref_cnt_d;
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!dqm[0]) mem[beat_addr][7:0]  <= dq_i[7:0];
            if (!dqm[1]) mem[beat_addr][15:8] <= dq_i[15:8];
        end
    end

    assign dq_o        = dq_o_q;
    assign dq_oe       = dq_oe_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign refresh_cnt = ref_cnt_q;
endmodule

// File: tb/tb_sdram_device_model.sv
module tb_sdram_device_model;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_BST = 3'b110;

    logic clk = 1'b0;
    logic rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0] ba, dqm;
    logic [11:0] addr;
    logic [15:0] dq_i, dq_o, refresh_cnt;
    logic dq_oe, init_done, err;
    logic [2:0] err_code;

    always #5 clk = ~clk;

    sdram_device_model dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm), .dq_i(dq_i), .dq_o(dq_o),
        .dq_oe(dq_oe), .init_done(init_done), .err(err), .err_code(err_code),
        .refresh_cnt(refresh_cnt)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        oe;
        logic        chk_dq;
        logic [15:0] exp_dq;
        logic        err;
        logic [2:0]  code;
        logic        init;
    } vec_t;

    vec_t vecs[$];
    int n_chk = 0;
    int n_fail = 0;
    int ref_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1ns after an edge, so outputs seen on return reflect that edge.
    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                         input logic [1:0] m, input logic [15:0] d);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dqm = m; dq_i = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                                input logic [1:0] m, input logic [15:0] d, input logic oe,
                                input logic cd, input logic [15:0] ed, input logic e,
                                input logic [2:0] code, input logic init);
        vec_t v;
        v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.dq = d; v.oe = oe;
        v.chk_dq = cd; v.exp_dq = ed; v.err = e; v.code = code; v.init = init;
        vecs.push_back(v);
    endfunction

    initial begin
        // cmd  ba  addr     dqm    dq        oe cdq exp_dq  err code init
        add(C_RD,  0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 3'd1, 0);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0);
        add(C_PRE, 0, 12'h400, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0);
        add(C_REF, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0);
        add(C_REF, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 0);
        add(C_LMR, 0, 12'h022, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        // BL4 CL2 write then wrapped read
        add(C_ACT, 1, 12'h003, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_WR,  1, 12'h004, 2'b00, 16'h1111, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h2222, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h3333, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h4444, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_RD,  1, 12'h006, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'h3333, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'h4444, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'h1111, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'h2222, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        // write byte mask, then read DQM latency
        add(C_WR,  1, 12'h010, 2'b00, 16'h1234, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_BST, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_WR,  1, 12'h010, 2'b10, 16'hABCD, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_BST, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_RD,  1, 12'h010, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'h12CD, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b11, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        // CL3 full page, wrap past column FF, BURST TERMINATE
        add(C_PRE, 0, 12'h400, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_LMR, 0, 12'h037, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_ACT, 2, 12'h005, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_WR,  2, 12'h0FE, 2'b00, 16'hAAAA, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'hBBBB, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'hCCCC, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_BST, 0, 12'h000, 2'b00, 16'hDDDD, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_RD,  2, 12'h0FE, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hAAAA, 0, 3'd0, 1);
        add(C_BST, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hBBBB, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hCCCC, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        // one violation each
        add(C_ACT, 2, 12'h005, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 3'd2, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_RD,  0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 3'd3, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_ACT, 3, 12'h001, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_RD,  3, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 3'd4, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_REF, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 3'd5, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        // bank 2 contents untouched by the rejected commands
        add(C_RD,  2, 12'h0FE, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hAAAA, 0, 3'd0, 1);
        add(C_BST, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hBBBB, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 1, 1, 16'hCCCC, 0, 3'd0, 1);
        add(C_NOP, 0, 12'h000, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 3'd0, 1);

        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
        ba = '0; addr = '0; dqm = '0; dq_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_dq_o", 32'(dq_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_refresh_cnt", 32'(refresh_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].dq);
            if (vecs[i].cmd == C_REF && !vecs[i].err) ref_exp++;
            chk($sformatf("v%0d_dq_oe", i), 32'(dq_oe), 32'(vecs[i].oe));
            if (vecs[i].chk_dq) chk($sformatf("v%0d_dq_o", i), 32'(dq_o), 32'(vecs[i].exp_dq));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            if (vecs[i].err) chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(vecs[i].code));
            chk($sformatf("v%0d_init_done", i), 32'(init_done), 32'(vecs[i].init));
            chk($sformatf("v%0d_refresh_cnt", i), 32'(refresh_cnt), 32'(ref_exp));
        end

        // Reset in the middle of a CL2 BL4 read burst.
        drive(C_PRE, 0, 12'h400, 2'b00, 16'h0000);
        drive(C_LMR, 0, 12'h022, 2'b00, 16'h0000);
        drive(C_ACT, 1, 12'h003, 2'b00, 16'h0000);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        drive(C_RD,  1, 12'h004, 2'b00, 16'h0000);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("pre_rst_word0", 32'(dq_o), 32'h1111);
        rst = 1'b1;
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("midrst_dq_oe", 32'(dq_oe), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        chk("midrst_refresh_cnt", 32'(refresh_cnt), 32'd0);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        rst = 1'b0;
        drive(C_PRE, 0, 12'h400, 2'b00, 16'h0000);
        drive(C_REF, 0, 12'h000, 2'b00, 16'h0000);
        drive(C_REF, 0, 12'h000, 2'b00, 16'h0000);
        drive(C_LMR, 0, 12'h022, 2'b00, 16'h0000);
        chk("reinit_init_done", 32'(init_done), 32'd1);
        chk("reinit_refresh_cnt", 32'(refresh_cnt), 32'd2);
        drive(C_ACT, 1, 12'h003, 2'b00, 16'h0000);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        drive(C_RD,  1, 12'h004, 2'b00, 16'h0000);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("retain_word0", 32'(dq_o), 32'h1111);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("retain_word1", 32'(dq_o), 32'h2222);
        // cke low for one edge: everything, including the burst, holds.
        cke = 1'b0;
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("cke_hold_dq_o", 32'(dq_o), 32'h2222);
        chk("cke_hold_dq_oe", 32'(dq_oe), 32'd1);
        cke = 1'b1;
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("retain_word2", 32'(dq_o), 32'h3333);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("retain_word3", 32'(dq_o), 32'h4444);
        drive(C_NOP, 0, 12'h000, 2'b00, 16'h0000);
        chk("burst_end_dq_oe", 32'(dq_oe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
